clock_set_ctrl: RTL and testbench

Timekeeping and time-set controller for the digital clock. It sits directly upstream of the registered display muxes. It produces the live hours/minutes/seconds values and the per-field select lines: sel=1 shows digits, sel=0 shows blank. Button-driven FSM edits hours and minutes; the field being edited blinks.

---
 rtl/clock_set_ctrl_if.sv | 26 ++
 rtl/clock_set_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_clock_set_ctrl.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/clock_set_ctrl_if.sv
// Button and display bus for clock_set_ctrl.
// The button side (master) drives the debounced button levels. The controller
// side (slave) drives the time fields, the display selects and the debug state.
// There is no valid/ready handshake: buttons are levels sampled on every clk
// rising edge, and every output is a register that is valid on every cycle.
interface clock_set_ctrl_if;
    logic       btn_mode;
    logic       btn_inc;
    logic [4:0] hours;
    logic [5:0] minutes;
    logic [5:0] seconds;
    logic       sel_hour;
    logic       sel_min;
    logic       setting;
    logic [1:0] state_dbg;

    modport master (
        output btn_mode, btn_inc,
        input  hours, minutes, seconds, sel_hour, sel_min, setting, state_dbg
    );

    modport slave (
        input  btn_mode, btn_inc,
        output hours, minutes, seconds, sel_hour, sel_min, setting, state_dbg
    );
endinterface

// File: rtl/clock_set_ctrl.sv
// Timekeeping and time-set controller for the digital clock.
// Keeps hours/minutes/seconds, lets the user set hours then minutes with the
// mode/inc buttons, and blinks the field being edited through the display
// selects (sel=1 digits, sel=0 blank). All outputs are registered.
// Optional build macro: CLOCK_SET_AUTO_REPEAT_EN enables auto-repeat of a held
// inc button in the set states (HOLD_TICKS first delay, REPEAT_TICKS interval).
module clock_set_ctrl #(
    parameter int TICKS_PER_SEC    = 50000000,
    parameter int BLINK_HALF_TICKS = 25000000,
    parameter int HOLD_TICKS       = 25000000,
    parameter int REPEAT_TICKS     = 10000000
) (
    input  logic             clk,
    input  logic             reset_,
    clock_set_ctrl_if.slave  bus
);

    localparam int PW = $clog2(TICKS_PER_SEC);
    localparam int BW = $clog2(BLINK_HALF_TICKS + 1);

    // Reject parameter values the counters cannot represent.
    if (TICKS_PER_SEC < 2 || BLINK_HALF_TICKS < 1 || HOLD_TICKS < 1 || REPEAT_TICKS < 1) begin : g_bad_param
        $error("clock_set_ctrl: invalid parameter value");
    end

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_SET_HOUR = 2'd1,
        ST_SET_MIN  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [BW-1:0]   blink_cnt_q, blink_cnt_d;
    logic            blink_q, blink_d;
    logic [4:0]      hours_q, hours_d;
    logic [5:0]      minutes_q, minutes_d;
    logic [5:0]      seconds_q, seconds_d;
    logic            mode_prev_q, inc_prev_q;
    logic            sel_hour_q, sel_hour_d;
    logic            sel_min_q, sel_min_d;
    logic            setting_q, setting_d;

    logic            mode_press;
    logic            inc_press;
    logic            inc_evt;

    assign mode_press = bus.btn_mode & ~mode_prev_q;
    assign inc_press  = bus.btn_inc & ~inc_prev_q;

`ifdef CLOCK_SET_AUTO_REPEAT_EN
    localparam int RMAX = (HOLD_TICKS > REPEAT_TICKS) ? HOLD_TICKS : REPEAT_TICKS;
    localparam int RW   = $clog2(RMAX + 1);

    // rep_cnt_q counts cycles since the press (or since the last repeat);
    // zero means no press is being tracked. rep_phase_q is set once the
    // initial hold delay has expired and the shorter repeat interval applies.
    logic [RW-1:0] rep_cnt_q, rep_cnt_d;
    logic          rep_phase_q, rep_phase_d;
    logic          rep_fire;

    // Auto-repeat tracking: restart on a press, clear on release or state change.
    always_comb begin
        rep_cnt_d   = rep_cnt_q;
        rep_phase_d = rep_phase_q;
        rep_fire    = 1'b0;
        if (state_q == ST_RUN || mode_press || !bus.btn_inc) begin
            rep_cnt_d   = '0;
            rep_phase_d = 1'b0;
        end else if (inc_press) begin
            rep_cnt_d   = RW'(1);
            rep_phase_d = 1'b0;
        end else if (rep_cnt_q != '0) begin
            if ((!rep_phase_q && rep_cnt_q == RW'(HOLD_TICKS)) ||
                ( rep_phase_q && rep_cnt_q == RW'(REPEAT_TICKS))) begin
                rep_fire    = 1'b1;
                rep_cnt_d   = RW'(1);
                rep_phase_d = 1'b1;
            end else begin
                rep_cnt_d = rep_cnt_q + RW'(1);
            end
        end
    end

    // Auto-repeat registers.
    always_ff @(posedge clk) begin
        if (reset_) begin
            rep_cnt_q   <= '0;
            rep_phase_q <= 1'b0;
        end else begin
            rep_cnt_q   <= rep_cnt_d;
            rep_phase_q <= rep_phase_d;
        end
    end

    assign inc_evt = inc_press | rep_fire;
`else
    assign inc_evt = inc_press;
`endif

    // Next state, time keeping/editing, blink and registered output values.
    always_comb begin
        state_d     = state_q;
        presc_d     = presc_q;
        hours_d     = hours_q;
        minutes_d   = minutes_q;
        seconds_d   = seconds_q;
        blink_d     = blink_q;
        blink_cnt_d = blink_cnt_q;

        case (state_q)
            ST_RUN: begin
                if (mode_press) begin
                    // Time freezes with seconds cleared for the edit.
                    state_d   = ST_SET_HOUR;
                    seconds_d = 6'd0;
                    presc_d   = '0;
                end else if (presc_q == PW'(TICKS_PER_SEC - 1)) begin
                    presc_d = '0;
                    if (seconds_q == 6'd59) begin
                        seconds_d = 6'd0;
                        if (minutes_q == 6'd59) begin
                            minutes_d = 6'd0;
                            hours_d   = (hours_q == 5'd23) ? 5'd0 : hours_q + 5'd1;
                        end else begin
                            minutes_d = minutes_q + 6'd1;
                        end
                    end else begin
                        seconds_d = seconds_q + 6'd1;
                    end
                end else begin
                    presc_d = presc_q + PW'(1);
                end
            end
            ST_SET_HOUR: begin
                if (mode_press) begin
                    state_d = ST_SET_MIN;
                end else if (inc_evt) begin
                    hours_d = (hours_q == 5'd23) ? 5'd0 : hours_q + 5'd1;
                end
            end
            ST_SET_MIN: begin
                if (mode_press) begin
                    // Prescaler restarts so a full second elapses before the first tick.
                    state_d = ST_RUN;
                    presc_d = '0;
                end else if (inc_evt) begin
                    minutes_d = (minutes_q == 6'd59) ? 6'd0 : minutes_q + 6'd1;
                end
            end
            default: begin
                state_d = ST_RUN;
                presc_d = '0;
            end
        endcase

        if (state_d != state_q) begin
            blink_d     = 1'b1;
            blink_cnt_d = '0;
        end else if (state_q == ST_RUN) begin
            blink_d     = 1'b1;
            blink_cnt_d = '0;
        end else if (blink_cnt_q == BW'(BLINK_HALF_TICKS - 1)) begin
            blink_d     = ~blink_q;
            blink_cnt_d = '0;
        end else begin
            blink_cnt_d = blink_cnt_q + BW'(1);
        end

        sel_hour_d = (state_d != ST_SET_HOUR) | blink_d;
        sel_min_d  = (state_d != ST_SET_MIN) | blink_d;
        setting_d  = (state_d != ST_RUN);
    end

    // State and output registers; button history resets high so a held
    // button gives no edge until it is released and pressed again.
    always_ff @(posedge clk) begin
        if (reset_) begin
            state_q     <= ST_RUN;
            presc_q     <= '0;
            blink_q     <= 1'b1;
            blink_cnt_q <= '0;
            hours_q     <= 5'd0;
            minutes_q   <= 6'd0;
            seconds_q   <= 6'd0;
            mode_prev_q <= 1'b1;
            inc_prev_q  <= 1'b1;
            sel_hour_q  <= 1'b1;
            sel_min_q   <= 1'b1;
            setting_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            blink_q     <= blink_d;
            blink_cnt_q <= blink_cnt_d;
            hours_q     <= hours_d;
            minutes_q   <= minutes_d;
            seconds_q   <= seconds_d;
            mode_prev_q <= bus.btn_mode;
            inc_prev_q  <= bus.btn_inc;
            sel_hour_q  <= sel_hour_d;
            sel_min_q   <= sel_min_d;
            setting_q   <= setting_d;
        end
    end

    assign bus.hours     = hours_q;
    assign bus.minutes   = minutes_q;
    assign bus.seconds   = seconds_q;
    assign bus.sel_hour  = sel_hour_q;
    assign bus.sel_min   = sel_min_q;
    assign bus.setting   = setting_q;
    assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Bench for clock_set_ctrl: directed scenarios plus random button traffic,
// checked every cycle against a time-of-day model kept in seconds-of-day.
module tb_clock_set_ctrl;

    localparam int T = 4;
    localparam int B = 2;
    localparam int H = 8;
    localparam int R = 4;

    logic clk = 1'b0;
    logic reset_ = 1'b1;

    clock_set_ctrl_if bus();

    clock_set_ctrl #(
        .TICKS_PER_SEC(T),
        .BLINK_HALF_TICKS(B),
        .HOLD_TICKS(H),
        .REPEAT_TICKS(R)
    ) dut (
        .clk(clk),
        .reset_(reset_),
        .bus(bus)
    );

    // Clock generation.
    always #5 clk = ~clk;

    int total = 0;
    int passed = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Model: m_t is seconds since midnight; m_state 0=running, 1=hour edit,
    // 2=minute edit; m_in_state counts cycles since entering the current mode;
    // m_held counts cycles since the inc press while held (-1 = not tracking).
    int m_state, m_t, m_presc, m_in_state, m_held;
    int m_mode_prev, m_inc_prev;
    bit m_valid = 1'b0;
    int mp, ip, fire, hh, mm;

    always @(posedge clk) begin
        if (reset_) begin
            m_state = 0; m_t = 0; m_presc = 0; m_in_state = 0; m_held = -1;
            m_mode_prev = 1; m_inc_prev = 1;
            m_valid = 1'b1;
        end else if (m_valid) begin
            mp = (bus.btn_mode && !m_mode_prev) ? 1 : 0;
            ip = (bus.btn_inc && !m_inc_prev) ? 1 : 0;
            fire = 0;
            if (mp != 0) begin
                m_state = (m_state + 1) % 3;
                if (m_state == 1) m_t = m_t - (m_t % 60);
                m_presc = 0;
                m_in_state = 0;
                m_held = -1;
            end else if (m_state == 0) begin
                m_presc++;
                if (m_presc == T) begin
                    m_presc = 0;
                    m_t = (m_t + 1) % 86400;
                end
            end else begin
                m_in_state++;
                if (ip != 0) begin
                    fire = 1;
                    m_held = 0;
                end else if (bus.btn_inc && m_held >= 0) begin
                    m_held++;
`ifdef CLOCK_SET_AUTO_REPEAT_EN
                    if (m_held == H || (m_held > H && (m_held - H) % R == 0)) fire = 1;
`endif
                end else begin
                    m_held = -1;
                end
                if (fire != 0) begin
                    hh = m_t / 3600;
                    mm = (m_t / 60) % 60;
                    if (m_state == 1) hh = (hh + 1) % 24;
                    else mm = (mm + 1) % 60;
                    m_t = hh * 3600 + mm * 60 + (m_t % 60);
                end
            end
            m_mode_prev = bus.btn_mode ? 1 : 0;
            m_inc_prev = bus.btn_inc ? 1 : 0;
        end
    end

    function automatic int exp_blink();
        if (m_state == 0) return 1;
        return ((m_in_state / B) % 2 == 0) ? 1 : 0;
    endfunction

    // Per-cycle compare, away from the active edge.
    always @(negedge clk) begin
        if (m_valid) begin
            chk("hours", int'(bus.hours), m_t / 3600);
            chk("minutes", int'(bus.minutes), (m_t / 60) % 60);
            chk("seconds", int'(bus.seconds), m_t % 60);
            chk("sel_hour", int'(bus.sel_hour), (m_state != 1 || exp_blink() != 0) ? 1 : 0);
            chk("sel_min", int'(bus.sel_min), (m_state != 2 || exp_blink() != 0) ? 1 : 0);
            chk("setting", int'(bus.setting), (m_state != 0) ? 1 : 0);
        end
    end

    task automatic press_mode();
        @(negedge clk) bus.btn_mode = 1'b1;
        @(negedge clk) bus.btn_mode = 1'b0;
    endtask

    task automatic press_inc(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk) bus.btn_inc = 1'b1;
            @(negedge clk) bus.btn_inc = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk) reset_ = 1'b1;
        @(negedge clk) reset_ = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    int seq[6];

    initial begin
        bus.btn_mode = 1'b0;
        bus.btn_inc = 1'b0;
        seq = '{1, 1, 0, 0, 1, 1};

        // Reset state and one minute of running.
        wait_cycles(2);
        chk("reset_hours", int'(bus.hours), 0);
        chk("reset_sel_hour", int'(bus.sel_hour), 1);
        chk("reset_setting", int'(bus.setting), 0);
        reset_ = 1'b0;
        wait_cycles(240);
        chk("run240_minutes", int'(bus.minutes), 1);
        chk("run240_seconds", int'(bus.seconds), 0);
        chk("run240_hours", int'(bus.hours), 0);

        // Set 23:59 then roll over midnight.
        do_reset();
        press_mode();
        press_inc(23);
        press_mode();
        press_inc(59);
        chk("set_hours", int'(bus.hours), 23);
        chk("set_minutes", int'(bus.minutes), 59);
        press_mode();
        wait_cycles(240);
        chk("rollover_hours", int'(bus.hours), 0);
        chk("rollover_minutes", int'(bus.minutes), 0);
        chk("rollover_seconds", int'(bus.seconds), 0);
        chk("rollover_setting", int'(bus.setting), 0);

        // Blink pattern on entering hour edit.
        @(negedge clk) bus.btn_mode = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            bus.btn_mode = 1'b0;
            chk("blink_sel_hour", int'(bus.sel_hour), seq[i]);
            chk("blink_sel_min", int'(bus.sel_min), 1);
            chk("blink_setting", int'(bus.setting), 1);
        end

        // Simultaneous mode and inc: mode wins.
        press_inc(5);
        @(negedge clk) begin bus.btn_mode = 1'b1; bus.btn_inc = 1'b1; end
        @(negedge clk) begin bus.btn_mode = 1'b0; bus.btn_inc = 1'b0; end
        chk("simul_hours", int'(bus.hours), 5);
        press_inc(37);
        chk("simul_minutes", int'(bus.minutes), 37);
        chk("simul_hours_kept", int'(bus.hours), 5);

        // Reset during minute edit with inc held.
        @(negedge clk) begin bus.btn_inc = 1'b1; reset_ = 1'b1; end
        @(negedge clk) reset_ = 1'b0;
        chk("midreset_minutes", int'(bus.minutes), 0);
        chk("midreset_hours", int'(bus.hours), 0);
        chk("midreset_setting", int'(bus.setting), 0);
        chk("midreset_sel_min", int'(bus.sel_min), 1);
        press_mode();
        wait_cycles(3);
        chk("held_inc_hours", int'(bus.hours), 0);
        chk("held_inc_setting", int'(bus.setting), 1);
        @(negedge clk) bus.btn_inc = 1'b0;

        // Hold inc for 20 cycles in minute edit.
        press_mode();
        @(negedge clk) bus.btn_inc = 1'b1;
        wait_cycles(19);
        @(negedge clk) bus.btn_inc = 1'b0;
`ifdef CLOCK_SET_AUTO_REPEAT_EN
        chk("hold_minutes", int'(bus.minutes), 4);
`else
        chk("hold_minutes", int'(bus.minutes), 1);
`endif
        press_mode();

        // Random button traffic with occasional reset.
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            bus.btn_mode = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 7) == 0) bus.btn_inc = ~bus.btn_inc;
            reset_ = ($urandom_range(0, 399) == 0);
        end
        @(negedge clk) reset_ = 1'b0;
        wait_cycles(2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
